v_list_walker: RTL and testbench

Query-bus initiator for the list lookup pipe. It accepts a "dump list" command for one product ID and walks levels 0..listsize-1 by issuing one lookup per level on the list query bus. Each returned key/volume tuple goes into a 2-entry output buffer and streams out under valid/ready. Update-pipeline hazards (error with non-zero listsize) are retried after a fixed backoff. The block sits between a host/readout client and the query pipe, on the initiator side of the same bus.

---
 rtl/v_pkg.sv | 25 ++
 rtl/v_list_walker_if.sv | 57 +++++
 rtl/v_list_walker.sv | 217 +++++++++++++++++++++
 tb/tb_v_list_walker.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/v_pkg.sv
// ---------------------------------------------------------------------------
// v_pkg
// Shared types for the list lookup pipe: product IDs, list levels, keys,
// volumes, list sizes, and the record format held in the walker's output
// buffer.
// ---------------------------------------------------------------------------
package v_pkg;

  typedef logic [7:0]  id_t;
  typedef logic [4:0]  level_t;
  typedef logic [15:0] key_t;
  typedef logic [15:0] volume_t;
  typedef logic [4:0]  listsize_t;

  // One output record; payload fields are don't-care when empty or err is set
  typedef struct packed {
    key_t    key;
    volume_t size;
    level_t  level;
    logic    last;
    logic    empty;
    logic    err;
  } rec_t;

endpackage

// File: rtl/v_list_walker_if.sv
// ---------------------------------------------------------------------------
// v_list_walker_if
// Bundles the three buses around the list walker:
//   cmd_* : walk request from the host (vld/rdy)
//   lut_* : lookup issue and the response that returns one cycle later
//   rsp_* : output record stream (vld/rdy)
//   busy  : walker activity status
// modport master : the walker (query initiator, record producer)
// modport slave  : the environment (host, lookup pipe, record consumer)
// ---------------------------------------------------------------------------
interface v_list_walker_if;
  import v_pkg::*;

  logic      cmd_vld;
  id_t       cmd_prod_id;
  logic      cmd_rdy;

  logic      lut_vld;
  id_t       lut_prod_id;
  level_t    lut_level;
  key_t      lut_key;
  volume_t   lut_size;
  logic      lut_error;
  listsize_t lut_listsize;

  logic      rsp_vld;
  logic      rsp_rdy;
  key_t      rsp_key;
  volume_t   rsp_size;
  level_t    rsp_level;
  logic      rsp_last;
  logic      rsp_empty;
  logic      rsp_err;

  logic      busy;

  modport master (
    input  cmd_vld, cmd_prod_id,
    input  lut_key, lut_size, lut_error, lut_listsize,
    input  rsp_rdy,
    output cmd_rdy,
    output lut_vld, lut_prod_id, lut_level,
    output rsp_vld, rsp_key, rsp_size, rsp_level, rsp_last, rsp_empty, rsp_err,
    output busy
  );

  modport slave (
    output cmd_vld, cmd_prod_id,
    output lut_key, lut_size, lut_error, lut_listsize,
    output rsp_rdy,
    input  cmd_rdy,
    input  lut_vld, lut_prod_id, lut_level,
    input  rsp_vld, rsp_key, rsp_size, rsp_level, rsp_last, rsp_empty, rsp_err,
    input  busy
  );

endinterface

// File: rtl/v_list_walker.sv
// ---------------------------------------------------------------------------
// v_list_walker
// Accepts a "dump list" command for one product and walks levels
// 0..listsize-1, issuing one lookup per level. Each returned key/volume goes
// into a 2-entry output buffer streamed out under valid/ready. Hazard
// responses (error with non-zero listsize) are retried after BACKOFF_CYCLES
// idle cycles, up to MAX_RETRY times per level.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-low reset
//   bus  : v_list_walker_if.master (cmd, lut query/response, rsp stream, busy)
// ---------------------------------------------------------------------------
module v_list_walker #(
  parameter int MAX_RETRY      = 7,
  parameter int BACKOFF_CYCLES = 4   // must be >= 1
) (
  input  logic             clk,
  input  logic             rst,
  v_list_walker_if.master  bus
);
  import v_pkg::*;

  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam int BW = $clog2(BACKOFF_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RESP    = 2'd2,
    BACKOFF = 2'd3
  } state_t;

  state_t          state_q;
  id_t             prod_q;
  level_t          level_q;
  logic [RW-1:0]   retry_q;
  logic [BW-1:0]   boff_q;
  logic            cmd_rdy_q;
  logic            lut_vld_q;
  logic            busy_q;

  rec_t            head_q;
  rec_t            tail_q;
  logic [1:0]      cnt_q;
  logic [1:0]      cnt_d;
  logic            rsp_vld_q;

  logic            push_s;
  logic            pop_s;
  logic            term_s;    // response ends the walk
  logic            retry_s;   // response is a retryable hazard
  rec_t            rec_s;

  // Response decode: classifies the lookup result sampled in RESP
  always_comb begin
    push_s  = 1'b0;
    term_s  = 1'b0;
    retry_s = 1'b0;
    rec_s   = '0;
    if (state_q == RESP) begin
      if ((level_q == '0) && (bus.lut_listsize == '0)) begin
        // Empty list wins over the hazard flag
        push_s     = 1'b1;
        term_s     = 1'b1;
        rec_s.empty = 1'b1;
        rec_s.last  = 1'b1;
      end else if (bus.lut_error) begin
        if (retry_q == RW'(MAX_RETRY)) begin
          push_s    = 1'b1;
          term_s    = 1'b1;
          rec_s.err  = 1'b1;
          rec_s.last = 1'b1;
        end else begin
          retry_s = 1'b1;
        end
      end else if (level_q >= bus.lut_listsize) begin
        // List shrank under the walk
        push_s    = 1'b1;
        term_s    = 1'b1;
        rec_s.err  = 1'b1;
        rec_s.last = 1'b1;
      end else begin
        push_s      = 1'b1;
        rec_s.key   = bus.lut_key;
        rec_s.size  = bus.lut_size;
        rec_s.level = level_q;
        rec_s.last  = (level_q == (bus.lut_listsize - listsize_t'(1)));
        term_s      = rec_s.last;
      end
    end else begin
      push_s = 1'b0;
    end
  end

  // Buffer occupancy next-state
  always_comb begin
    pop_s = rsp_vld_q & bus.rsp_rdy;
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Output buffer: head_q always holds the oldest record
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= 2'd0;
      rsp_vld_q <= 1'b0;
      head_q    <= '0;
      tail_q    <= '0;
    end else begin
      cnt_q     <= cnt_d;
      rsp_vld_q <= (cnt_d != 2'd0);
      case ({push_s, pop_s})
        2'b10: begin
          if (cnt_q == 2'd0) head_q <= rec_s;
          else               tail_q <= rec_s;
        end
        2'b01: head_q <= tail_q;
        2'b11: begin
          if (cnt_q == 2'd1) begin
            head_q <= rec_s;
          end else begin
            head_q <= tail_q;
            tail_q <= rec_s;
          end
        end
        default: begin
          head_q <= head_q;
        end
      endcase
    end
  end

  // Walk FSM; lut_vld_q is precomputed from next-cycle buffer occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      prod_q    <= '0;
      level_q   <= '0;
      retry_q   <= '0;
      boff_q    <= '0;
      cmd_rdy_q <= 1'b1;
      lut_vld_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      busy_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (bus.cmd_vld && cmd_rdy_q) begin
            prod_q    <= bus.cmd_prod_id;
            level_q   <= '0;
            retry_q   <= '0;
            cmd_rdy_q <= 1'b0;
            lut_vld_q <= (cnt_d != 2'd2);
            state_q   <= ISSUE;
          end else begin
            busy_q <= (cnt_d != 2'd0);
          end
        end
        ISSUE: begin
          if (lut_vld_q) begin
            lut_vld_q <= 1'b0;
            state_q   <= RESP;
          end else begin
            lut_vld_q <= (cnt_d != 2'd2);
          end
        end
        RESP: begin
          if (term_s) begin
            retry_q   <= '0;
            cmd_rdy_q <= 1'b1;
            state_q   <= IDLE;
          end else if (retry_s) begin
            retry_q <= retry_q + RW'(1);
            boff_q  <= BW'(BACKOFF_CYCLES);
            state_q <= BACKOFF;
          end else begin
            retry_q   <= '0;
            level_q   <= level_q + level_t'(1);
            lut_vld_q <= (cnt_d != 2'd2);
            state_q   <= ISSUE;
          end
        end
        BACKOFF: begin
          // Counter starts at BACKOFF_CYCLES, so exactly that many cycles here
          if (boff_q == BW'(1)) begin
            lut_vld_q <= (cnt_d != 2'd2);
            state_q   <= ISSUE;
          end else begin
            boff_q <= boff_q - BW'(1);
          end
        end
        default: begin
          cmd_rdy_q <= 1'b1;
          lut_vld_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_rdy     = cmd_rdy_q;
  assign bus.lut_vld     = lut_vld_q;
  assign bus.lut_prod_id = prod_q;
  assign bus.lut_level   = level_q;
  assign bus.rsp_vld     = rsp_vld_q;
  assign bus.rsp_key     = head_q.key;
  assign bus.rsp_size    = head_q.size;
  assign bus.rsp_level   = head_q.level;
  assign bus.rsp_last    = head_q.last;
  assign bus.rsp_empty   = head_q.empty;
  assign bus.rsp_err     = head_q.err;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_v_list_walker.sv
// ---------------------------------------------------------------------------
// tb_v_list_walker
// Scripted lookup-pipe responder plus a list-walk reference model feeding a
// record scoreboard; directed timing scenarios followed by randomized walks.
// ---------------------------------------------------------------------------
module tb_v_list_walker;
  import v_pkg::*;

  localparam int MAXR = 7;
  localparam int BOFF = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  v_list_walker_if bus();

  v_list_walker #(.MAX_RETRY(MAXR), .BACKOFF_CYCLES(BOFF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit last;
    bit empty;
    bit err;
    int key;
    int size;
    int level;
  } exp_t;

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  int   iss_cyc[$];
  int   iss_lvl[$];
  int   rec_cyc[$];

  // Walk script shared by the responder and the reference model
  int s_prod;
  int s_len;
  int s_shr_lvl;
  int s_shr_val;
  int s_haz[32];
  int s_att[32];
  int rdy_mode = 0;   // 0: always ready, 1: random, 2: never ready

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int ls_at(input int lvl);
    return (s_shr_lvl >= 0 && lvl >= s_shr_lvl) ? s_shr_val : s_len;
  endfunction

  function automatic int key_of(input int p, input int lvl);
    return (p * 256 + lvl * 37 + 1) % 65536;
  endfunction

  function automatic int size_of(input int p, input int lvl);
    return (lvl * 113 + p * 7 + 3) % 65536;
  endfunction

  task automatic setup(input int p, input int len, input int shl, input int shv);
    s_prod = p; s_len = len; s_shr_lvl = shl; s_shr_val = shv;
    for (int i = 0; i < 32; i++) begin
      s_haz[i] = 0;
      s_att[i] = 0;
    end
    iss_cyc.delete(); iss_lvl.delete(); rec_cyc.delete();
  endtask

  // Reference walk: what records should appear and how many lookups it takes
  task automatic model(output int nq);
    int   lvl = 0;
    int   tries = 0;
    int   ls;
    bit   er;
    exp_t e;
    nq = 0;
    forever begin
      nq++;
      ls = ls_at(lvl);
      er = (tries < s_haz[lvl]) || (ls == 0);
      e = '{last: 1'b1, empty: 1'b0, err: 1'b0, key: 0, size: 0, level: 0};
      if (lvl == 0 && ls == 0) begin
        e.empty = 1'b1; exp_q.push_back(e); break;
      end
      if (er) begin
        if (tries == MAXR) begin
          e.err = 1'b1; exp_q.push_back(e); break;
        end
        tries++;
        continue;
      end
      if (lvl >= ls) begin
        e.err = 1'b1; exp_q.push_back(e); break;
      end
      e.key = key_of(s_prod, lvl); e.size = size_of(s_prod, lvl);
      e.level = lvl; e.last = (lvl == ls - 1);
      exp_q.push_back(e);
      if (e.last) break;
      lvl++;
      tries = 0;
    end
  endtask

  // Lookup pipe: answer each issue, held through the following cycle
  initial begin
    int l;
    int a;
    bus.lut_key = '0; bus.lut_size = '0; bus.lut_error = 1'b0; bus.lut_listsize = '0;
    forever begin
      @(negedge clk);
      if (rst && bus.lut_vld) begin
        l = int'(bus.lut_level);
        iss_cyc.push_back(cyc);
        iss_lvl.push_back(l);
        check("lut_prod_id", bus.lut_prod_id, s_prod);
        a = s_att[l];
        s_att[l] = a + 1;
        bus.lut_listsize = listsize_t'(ls_at(l));
        bus.lut_error    = (a < s_haz[l]) || (ls_at(l) == 0);
        bus.lut_key      = key_t'(key_of(s_prod, l));
        bus.lut_size     = volume_t'(size_of(s_prod, l));
      end
    end
  end

  // Consumer ready pattern
  initial begin
    bus.rsp_rdy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.rsp_rdy = 1'b1;
        1:       bus.rsp_rdy = 1'($urandom_range(0, 1));
        default: bus.rsp_rdy = 1'b0;
      endcase
    end
  end

  // Scoreboard monitor: compares each transferred record against the model
  initial begin
    bit     stalled = 1'b0;
    longint snap = 0;
    longint pay;
    exp_t   e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        stalled = 1'b0;
      end else begin
        pay = longint'({bus.rsp_key, bus.rsp_size, bus.rsp_level,
                        bus.rsp_last, bus.rsp_empty, bus.rsp_err});
        if (stalled && bus.rsp_vld) check("rsp_hold", pay, snap);
        if (bus.rsp_vld && bus.rsp_rdy) begin
          rec_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            check("rsp_unexpected", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("rsp_last", bus.rsp_last, e.last);
            check("rsp_empty", bus.rsp_empty, e.empty);
            check("rsp_err", bus.rsp_err, e.err);
            if (!e.err && !e.empty) begin
              check("rsp_key", bus.rsp_key, e.key);
              check("rsp_size", bus.rsp_size, e.size);
              check("rsp_level", bus.rsp_level, e.level);
            end
          end
        end
        stalled = bus.rsp_vld && !bus.rsp_rdy;
        snap = pay;
      end
    end
  end

  task automatic wait_neg(input int n);
    do @(negedge clk); while (cyc < n);
  endtask

  // Present a command for the scripted product; t = acceptance cycle
  task automatic start_walk(output int t, output int nq);
    model(nq);
    @(posedge clk);
    #1;
    bus.cmd_vld = 1'b1;
    bus.cmd_prod_id = id_t'(s_prod);
    for (int k = 0; k < 300; k++) begin
      if (bus.cmd_rdy) break;
      @(posedge clk);
      #1;
    end
    check("cmd_accept", bus.cmd_rdy, 1);
    t = cyc;
    @(posedge clk);
    #1;
    bus.cmd_vld = 1'b0;
  endtask

  // Wait for the walker to go fully idle; ic = first idle cycle
  task automatic finish_walk(input int nq, output int ic);
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (!bus.busy) break;
    end
    ic = cyc;
    check("walk_idle", bus.busy, 0);
    check("missing_records", exp_q.size(), 0);
    check("query_count", iss_cyc.size(), nq);
  endtask

  initial begin
    int t;
    int nq;
    int ic;
    int l1[$];
    int v;
    bus.cmd_vld = 1'b0;
    bus.cmd_prod_id = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_lut_vld", bus.lut_vld, 0);
    check("rst_rsp_vld", bus.rsp_vld, 0);
    check("rst_cmd_rdy", bus.cmd_rdy, 1);
    check("rst_busy", bus.busy, 0);
    rst = 1'b1;

    // Nominal 3-level walk, consumer always ready
    setup(5, 3, -1, 0);
    start_walk(t, nq);
    finish_walk(nq, ic);
    check("nom_busy_drop_cycle", ic, t + 8);
    for (int i = 0; i < 3; i++) begin
      check("nom_issue_cycle", iss_cyc[i], t + 1 + 2 * i);
      check("nom_issue_level", iss_lvl[i], i);
      check("nom_record_cycle", rec_cyc[i], t + 3 + 2 * i);
    end

    // Empty list
    setup(6, 0, -1, 0);
    start_walk(t, nq);
    wait_neg(t + 3);
    check("empty_cmd_rdy", bus.cmd_rdy, 1);
    check("empty_rsp_vld", bus.rsp_vld, 1);
    finish_walk(nq, ic);
    check("empty_queries", iss_cyc.size(), 1);

    // Two hazards at level 1, then clean
    setup(7, 3, -1, 0);
    s_haz[1] = 2;
    start_walk(t, nq);
    finish_walk(nq, ic);
    l1.delete();
    foreach (iss_lvl[i]) if (iss_lvl[i] == 1) l1.push_back(iss_cyc[i]);
    check("haz_l1_queries", l1.size(), 3);
    for (int i = 1; i < 3; i++) check("haz_spacing", l1[i] - l1[i-1], 2 + BOFF);

    // Persistent hazard at level 0
    setup(8, 3, -1, 0);
    s_haz[0] = 100;
    start_walk(t, nq);
    finish_walk(nq, ic);
    check("exh_queries", iss_cyc.size(), MAXR + 1);

    // Backpressure: buffer fills, issuing stops, then resumes
    rdy_mode = 2;
    setup(9, 5, -1, 0);
    start_walk(t, nq);
    wait_neg(t + 20);
    check("bp_queries_stalled", iss_cyc.size(), 2);
    check("bp_lut_vld", bus.lut_vld, 0);
    check("bp_rsp_vld", bus.rsp_vld, 1);
    rdy_mode = 1;
    finish_walk(nq, ic);
    check("bp_queries_total", iss_cyc.size(), 5);

    // List shrinks from 4 to 2 when level 2 is queried
    rdy_mode = 0;
    setup(10, 4, 2, 2);
    start_walk(t, nq);
    finish_walk(nq, ic);
    check("shrink_queries", iss_cyc.size(), 3);

    // Reset pulsed mid-walk
    setup(11, 6, -1, 0);
    start_walk(t, nq);
    wait_neg(t + 4);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("midrst_lut_vld", bus.lut_vld, 0);
    check("midrst_rsp_vld", bus.rsp_vld, 0);
    check("midrst_cmd_rdy", bus.cmd_rdy, 1);
    check("midrst_busy", bus.busy, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    setup(12, 2, -1, 0);
    start_walk(t, nq);
    finish_walk(nq, ic);
    check("postrst_first_level", iss_lvl[0], 0);

    // Randomized walks, back to back while records may still be buffered
    rdy_mode = 1;
    for (int w = 0; w < 40; w++) begin
      if ($urandom_range(0, 4) == 0)
        setup($urandom_range(0, 255), $urandom_range(0, 6),
              $urandom_range(1, 5), $urandom_range(0, 5));
      else
        setup($urandom_range(0, 255), $urandom_range(0, 6), -1, 0);
      for (int i = 0; i < 8; i++) begin
        v = $urandom_range(0, 29);
        s_haz[i] = (v == 0) ? 9 : ((v < 4) ? v : 0);
      end
      start_walk(t, nq);
      for (int k = 0; k < 500; k++) begin
        @(negedge clk);
        if (bus.cmd_rdy) break;
      end
      check("rand_walk_done", bus.cmd_rdy, 1);
      check("rand_query_count", iss_cyc.size(), nq);
    end
    finish_walk(iss_cyc.size(), ic);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
